// File: rtl/fp32_seq_ctrl_pkg.sv
// fp32_seq_ctrl shared definitions.
// Default sizes and the sequencer state encoding.
package fp32_seq_ctrl_pkg;

  localparam int unsigned WIDTH_DEF   = 32;
  localparam int unsigned TIMEOUT_DEF = 63;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_SHIFT_IN  = 3'd1,
    S_ADD       = 3'd2,
    S_LOAD      = 3'd3,
    S_SHIFT_OUT = 3'd4
  } state_e;

endpackage

// File: rtl/fp32_seq_ctrl_sipo.sv
// sipo_reg: serial-in parallel-out shift register.
// MSB-first; a set enable shifts one bit in at the LSB.
module sipo_reg #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             bit_in,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] r_q;

  // Shift left on enable, hold otherwise.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_q <= '0;
    end else if (en) begin
      r_q <= {r_q[WIDTH-2:0], bit_in};
    end
  end

  assign q = r_q;

endmodule

// File: rtl/fp32_seq_ctrl.sv
// fp32_seq_ctrl: serial operand capture, adder
// handshake with timeout, and serial result unload.
module fp32_seq_ctrl
  import fp32_seq_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH   = WIDTH_DEF,
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
`ifdef USE_POWER_PINS
  inout  wire              VPWR,
  inout  wire              VGND,
`endif
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             ser_vld,
  input  logic             ser_a,
  input  logic             ser_b,
  output logic [WIDTH-1:0] op_a,
  output logic [WIDTH-1:0] op_b,
  output logic             add_go,
  input  logic             add_done,
  output logic             ldc,
  output logic             out_valid,
  output logic             out_last,
  output logic             busy,
  output logic             err
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  state_e          r_state;
  state_e          w_state_nx;
  logic [CW-1:0]   r_cnt;
  logic [CW-1:0]   w_cnt_nx;
  logic [TW-1:0]   r_tmo;
  logic [TW-1:0]   w_tmo_nx;
  logic            r_add_go;
  logic            w_add_go_nx;
  logic            r_ldc;
  logic            w_ldc_nx;
  logic            r_out_valid;
  logic            w_out_valid_nx;
  logic            r_out_last;
  logic            w_out_last_nx;
  logic            r_busy;
  logic            w_busy_nx;
  logic            r_err;
  logic            w_err_nx;
  logic            w_shift_en;

  assign w_shift_en = (r_state == S_SHIFT_IN) && ser_vld;

  sipo_reg #(.WIDTH(WIDTH)) u_sipo_a (
    .clk    (clk),
    .reset  (reset),
    .en     (w_shift_en),
    .bit_in (ser_a),
    .q      (op_a)
  );

  sipo_reg #(.WIDTH(WIDTH)) u_sipo_b (
    .clk    (clk),
    .reset  (reset),
    .en     (w_shift_en),
    .bit_in (ser_b),
    .q      (op_b)
  );

  // Next state plus next value of every registered output.
  // Strobes default low so each is a single-cycle pulse
  // unless a state explicitly re-asserts it.
  always_comb begin
    w_state_nx     = r_state;
    w_cnt_nx       = r_cnt;
    w_tmo_nx       = r_tmo;
    w_add_go_nx    = 1'b0;
    w_ldc_nx       = 1'b0;
    w_out_valid_nx = 1'b0;
    w_out_last_nx  = 1'b0;
    w_err_nx       = r_err;
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nx = S_SHIFT_IN;
          w_cnt_nx   = '0;
          w_err_nx   = 1'b0;
        end
      end
      S_SHIFT_IN: begin
        if (ser_vld) begin
          w_cnt_nx = r_cnt + CW'(1);
          if (r_cnt == CW'(WIDTH - 1)) begin
            w_state_nx  = S_ADD;
            w_tmo_nx    = '0;
            w_add_go_nx = 1'b1;
          end
        end
      end
      S_ADD: begin
        // add_done is blind during the add_go cycle itself.
        if (!r_add_go && add_done) begin
          w_state_nx = S_LOAD;
          w_ldc_nx   = 1'b1;
        end else if (r_tmo == TW'(TIMEOUT - 1)) begin
          w_state_nx = S_IDLE;
          w_err_nx   = 1'b1;
        end else begin
          w_tmo_nx = r_tmo + TW'(1);
        end
      end
      S_LOAD: begin
        w_state_nx     = S_SHIFT_OUT;
        w_cnt_nx       = '0;
        w_out_valid_nx = 1'b1;
      end
      S_SHIFT_OUT: begin
        if (r_cnt == CW'(WIDTH - 1)) begin
          w_state_nx = S_IDLE;
        end else begin
          w_cnt_nx       = r_cnt + CW'(1);
          w_out_valid_nx = 1'b1;
          w_out_last_nx  = (r_cnt == CW'(WIDTH - 2));
        end
      end
      default: begin
        w_state_nx = S_IDLE;
      end
    endcase
    w_busy_nx = (w_state_nx != S_IDLE);
  end

  // State and output registers; reset wins over everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_tmo       <= '0;
      r_add_go    <= 1'b0;
      r_ldc       <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_busy      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      r_cnt       <= w_cnt_nx;
      r_tmo       <= w_tmo_nx;
      r_add_go    <= w_add_go_nx;
      r_ldc       <= w_ldc_nx;
      r_out_valid <= w_out_valid_nx;
      r_out_last  <= w_out_last_nx;
      r_busy      <= w_busy_nx;
      r_err       <= w_err_nx;
    end
  end

  assign add_go    = r_add_go;
  assign ldc       = r_ldc;
  assign out_valid = r_out_valid;
  assign out_last  = r_out_last;
  assign busy      = r_busy;
  assign err       = r_err;

endmodule
